// File: rtl/branch_predictor_param_pkg.sv
// Shared types and helpers for the parametrised branch predictor (package bp_pkg).
// Optional return-address stack is enabled with the BP_RAS_EN macro.
package bp_pkg;

  typedef enum logic [1:0] {
    COND = 2'd0,
    JUMP = 2'd1,
    CALL = 2'd2,
    RET  = 2'd3
  } br_type_e;

  // Weakly not-taken: one below the midpoint of the counter range.
  function automatic logic [3:0] cnt_reset_val(input int unsigned cnt_bits);
    return 4'((1 << (cnt_bits - 1)) - 1);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_param_if.sv
// Query/train/flush bundle between the IF/EX stages and the branch predictor.
// master = pipeline side, slave = predictor side.
interface bp_if;
  logic [31:0] query_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] npc;
  logic        btb_hit;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_type;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic [31:0] perf_br;
  logic [31:0] perf_miss;

  modport master (
    output query_pc, upd_valid, upd_pc, upd_type, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, npc, btb_hit, mispredict, correct_pc,
           perf_br, perf_miss
  );

  modport slave (
    input  query_pc, upd_valid, upd_pc, upd_type, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, npc, btb_hit, mispredict, correct_pc,
           perf_br, perf_miss
  );
endinterface

// File: rtl/branch_predictor_param_ras.sv
// Circular return-address stack trained at resolution; used only when BP_RAS_EN is defined.
// A push when full silently overwrites the oldest entry.
module bp_ras
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic [31:0] i_push_data,
  output logic [31:0] o_top,
  output logic        o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]    r_stack [DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] w_push_ptr;
  logic             w_do_pop;

  assign w_push_ptr = r_top + 1'b1;
  assign w_do_pop   = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_top   <= w_push_ptr;
      r_count <= (r_count == FULL_CNT) ? r_count : r_count + 1'b1;
    end else if (w_do_pop) begin
      r_top   <= r_top - 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_stack[w_push_ptr] <= i_push_data;
    end
  end

  assign o_top   = r_stack[r_top];
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/branch_predictor_param.sv
// Direct-mapped BTB + bimodal BHT predictor with saturating perf counters.
// Define BP_RAS_EN to add the return-address stack (bp_ras) for RET-typed entries.
module branch_predictor_param
  import bp_pkg::*;
#(
  parameter int BTB_ENTRIES = 64,
  parameter int BHT_ENTRIES = 256,
  parameter int CNT_BITS    = 2,
  parameter int RAS_DEPTH   = 4
) (
  input  logic clk,
  input  logic rst,
  bp_if.slave  bp
);

  localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
  localparam int TAG_W     = 30 - BTB_IDX_W;
  localparam logic [CNT_BITS-1:0] CNT_RST = CNT_BITS'(cnt_reset_val(CNT_BITS));
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [BTB_ENTRIES-1:0] r_btb_valid;
  logic [TAG_W-1:0]       r_btb_tag    [BTB_ENTRIES];
  logic [31:0]            r_btb_target [BTB_ENTRIES];
  br_type_e               r_btb_type   [BTB_ENTRIES];
  logic [CNT_BITS-1:0]    r_bht        [BHT_ENTRIES];
  logic [31:0]            r_perf_br;
  logic [31:0]            r_perf_miss;

  logic [BTB_IDX_W-1:0] w_q_btb_idx, w_u_btb_idx;
  logic [BHT_IDX_W-1:0] w_q_bht_idx, w_u_bht_idx;
  logic [TAG_W-1:0]     w_q_tag, w_u_tag;
  br_type_e             w_q_type, w_u_type;
  logic                 w_btb_hit, w_pred_taken, w_use_ras, w_mispredict;
  logic                 w_btb_we, w_bht_we;
  logic [31:0]          w_pred_target, w_ras_top;
  logic [CNT_BITS-1:0]  w_bht_cur, w_bht_next;

  assign w_q_btb_idx = bp.query_pc[BTB_IDX_W+1:2];
  assign w_q_tag     = bp.query_pc[31:BTB_IDX_W+2];
  assign w_q_bht_idx = bp.query_pc[BHT_IDX_W+1:2];
  assign w_u_btb_idx = bp.upd_pc[BTB_IDX_W+1:2];
  assign w_u_tag     = bp.upd_pc[31:BTB_IDX_W+2];
  assign w_u_bht_idx = bp.upd_pc[BHT_IDX_W+1:2];
  assign w_u_type    = br_type_e'(bp.upd_type);

  // Query side reads registered tables directly, so a same-cycle update is not bypassed.
  always_comb begin
    w_q_type      = r_btb_type[w_q_btb_idx];
    w_btb_hit     = r_btb_valid[w_q_btb_idx] && (r_btb_tag[w_q_btb_idx] == w_q_tag);
    w_pred_taken  = w_btb_hit &&
                    ((w_q_type != COND) || r_bht[w_q_bht_idx][CNT_BITS-1]);
    w_pred_target = w_use_ras ? w_ras_top : r_btb_target[w_q_btb_idx];
  end

`ifdef BP_RAS_EN
  logic w_ras_empty;

  bp_ras #(
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .i_push      (bp.upd_valid && (w_u_type == CALL)),
    .i_pop       (bp.upd_valid && (w_u_type == RET)),
    .i_push_data (bp.upd_pc + 32'd4),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty)
  );

  assign w_use_ras = (w_q_type == RET) && !w_ras_empty;
`else
  logic w_unused_ras_depth;
  assign w_unused_ras_depth = ^RAS_DEPTH;
  assign w_use_ras          = 1'b0;
  assign w_ras_top          = '0;
`endif

  assign bp.btb_hit     = w_btb_hit;
  assign bp.pred_taken  = w_pred_taken;
  assign bp.pred_target = w_pred_target;
  assign bp.npc         = w_pred_taken ? w_pred_target : bp.query_pc + 32'd4;

  // Only taken resolutions allocate; not-taken never touches the BTB.
  assign w_btb_we = bp.upd_valid && bp.upd_taken;
  assign w_bht_we = bp.upd_valid && (w_u_type == COND);

  always_comb begin
    w_bht_cur  = r_bht[w_u_bht_idx];
    w_bht_next = w_bht_cur;
    if (bp.upd_taken) begin
      if (w_bht_cur != CNT_MAX) w_bht_next = w_bht_cur + 1'b1;
    end else begin
      if (w_bht_cur != '0) w_bht_next = w_bht_cur - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btb_valid <= '0;
    end else if (w_btb_we) begin
      r_btb_valid[w_u_btb_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_btb_we) begin
      r_btb_tag[w_u_btb_idx]    <= w_u_tag;
      r_btb_target[w_u_btb_idx] <= bp.upd_target;
      r_btb_type[w_u_btb_idx]   <= w_u_type;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_bht[i] <= CNT_RST;
      end
    end else if (w_bht_we) begin
      r_bht[w_u_bht_idx] <= w_bht_next;
    end
  end

  assign w_mispredict = bp.upd_valid &&
                        ((bp.upd_taken != bp.upd_pred_taken) ||
                         (bp.upd_taken && (bp.upd_pred_target != bp.upd_target)));

  assign bp.mispredict = w_mispredict;
  assign bp.correct_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_br   <= '0;
      r_perf_miss <= '0;
    end else begin
      if (bp.upd_valid) r_perf_br   <= sat_inc32(r_perf_br);
      if (w_mispredict) r_perf_miss <= sat_inc32(r_perf_miss);
    end
  end

  assign bp.perf_br   = r_perf_br;
  assign bp.perf_miss = r_perf_miss;

endmodule

// File: tb/tb_branch_predictor_param.sv
// Randomised self-checking bench for branch_predictor_param against a table-level model.
// Directed RAS scenarios run only when BP_RAS_EN is defined.
module tb_branch_predictor_param;
  import bp_pkg::*;

  localparam int BTB_N = 64;
  localparam int BHT_N = 256;
  localparam int CB    = 2;
  localparam int RD    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bp_if bp ();

  branch_predictor_param #(
    .BTB_ENTRIES (BTB_N),
    .BHT_ENTRIES (BHT_N),
    .CNT_BITS    (CB),
    .RAS_DEPTH   (RD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  // Reference model: plain arrays indexed by word address modulo table size.
  bit          m_valid [BTB_N];
  longint      m_tag   [BTB_N];
  logic [31:0] m_tgt   [BTB_N];
  int          m_type  [BTB_N];
  int          m_cnt   [BHT_N];
  longint      m_br, m_miss;
  logic [31:0] m_ras [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < BTB_N; i++) m_valid[i] = 1'b0;
    for (int i = 0; i < BHT_N; i++) m_cnt[i] = 2 ** (CB - 1) - 1;
    m_br   = 0;
    m_miss = 0;
    m_ras.delete();
  endfunction

  function automatic void model_query(input logic [31:0] pc, output bit hit,
                                      output bit tk, output logic [31:0] tgt);
    int bi;
    bi  = int'((pc / 4) % BTB_N);
    hit = m_valid[bi] && (m_tag[bi] == longint'(pc / (4 * BTB_N)));
    tk  = hit && ((m_type[bi] != 0) || (m_cnt[int'((pc / 4) % BHT_N)] >= 2 ** (CB - 1)));
    tgt = m_tgt[bi];
`ifdef BP_RAS_EN
    if (m_type[bi] == 3 && m_ras.size() > 0) tgt = m_ras[$];
`endif
  endfunction

  function automatic bit model_mis();
    return bp.upd_valid && ((bp.upd_taken != bp.upd_pred_taken) ||
                            (bp.upd_taken && (bp.upd_pred_target != bp.upd_target)));
  endfunction

  task automatic drive(input logic [31:0] qpc, input bit uv, input logic [31:0] upc,
                       input int ut, input bit utk, input logic [31:0] utgt,
                       input bit upt, input logic [31:0] uptgt);
    bp.query_pc        = qpc;
    bp.upd_valid       = uv;
    bp.upd_pc          = upc;
    bp.upd_type        = 2'(ut);
    bp.upd_taken       = utk;
    bp.upd_target      = utgt;
    bp.upd_pred_taken  = upt;
    bp.upd_pred_target = uptgt;
  endtask

  task automatic settle();
    bit          hit, tk;
    logic [31:0] tgt;
    @(negedge clk);
    model_query(bp.query_pc, hit, tk, tgt);
    check("btb_hit", 32'(bp.btb_hit), 32'(hit));
    check("pred_taken", 32'(bp.pred_taken), 32'(tk));
    if (hit) check("pred_target", bp.pred_target, tgt);
    check("npc", bp.npc, tk ? tgt : bp.query_pc + 32'd4);
    check("mispredict", 32'(bp.mispredict), 32'(model_mis()));
    if (bp.upd_valid) check("correct_pc", bp.correct_pc, bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4);
    check("perf_br", bp.perf_br, 32'(m_br));
    check("perf_miss", bp.perf_miss, 32'(m_miss));
  endtask

  task automatic commit();
    int bi, hi;
    @(posedge clk);
    if (bp.upd_valid) begin
      m_br++;
      if (model_mis()) m_miss++;
      bi = int'((bp.upd_pc / 4) % BTB_N);
      hi = int'((bp.upd_pc / 4) % BHT_N);
      if (bp.upd_taken) begin
        m_valid[bi] = 1'b1;
        m_tag[bi]   = longint'(bp.upd_pc / (4 * BTB_N));
        m_tgt[bi]   = bp.upd_target;
        m_type[bi]  = int'(bp.upd_type);
      end
      if (bp.upd_type == 2'd0) begin
        if (bp.upd_taken && m_cnt[hi] < 2 ** CB - 1) m_cnt[hi]++;
        if (!bp.upd_taken && m_cnt[hi] > 0) m_cnt[hi]--;
      end
`ifdef BP_RAS_EN
      if (bp.upd_type == 2'd2) begin
        m_ras.push_back(bp.upd_pc + 32'd4);
        if (m_ras.size() > RD) void'(m_ras.pop_front());
      end
      if (bp.upd_type == 2'd3 && m_ras.size() > 0) void'(m_ras.pop_back());
`endif
    end
    #1;
  endtask

  task automatic step();
    settle();
    commit();
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  task automatic random_step();
    logic [31:0] upc, qpc, utgt, ptg;
    int          ut;
    bit          utk, h, ptk, uv;
    upc  = rand_pc();
    qpc  = ($urandom_range(0, 3) == 0) ? upc : rand_pc();
    ut   = $urandom_range(0, 3);
    utk  = (ut == 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 7) != 0);
    utgt = 32'h1000 | (32'($urandom_range(0, 255)) << 2);
    uv   = ($urandom_range(0, 4) != 0);
    model_query(upc, h, ptk, ptg);
    if ($urandom_range(0, 1) == 0) begin
      ptk = bit'($urandom_range(0, 1));
      ptg = 32'h1000 | (32'($urandom_range(0, 255)) << 2);
    end
    drive(qpc, uv, upc, ut, utk, utgt, ptk, ptg);
    step();
  endtask

  initial begin
    bit          h, ptk;
    logic [31:0] ptg;
    model_reset();

    // In reset: tables empty, mispredict still follows the update inputs.
    drive(32'h100, 1'b1, 32'h40, 0, 1'b1, 32'h80, 1'b0, 32'h0);
    settle();
    check("rst_mis", 32'(bp.mispredict), 32'd1);
    drive(32'h100, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    settle();
    check("q100_taken", 32'(bp.pred_taken), 32'd0);
    check("q100_hit", 32'(bp.btb_hit), 32'd0);
    check("q100_npc", bp.npc, 32'h104);
    check("q100_br", bp.perf_br, 32'd0);
    commit();

    for (int k = 0; k < 2; k++) begin
      drive(32'h200, 1'b1, 32'h200, 0, 1'b1, 32'h80, 1'b0, 32'h0);
      settle();
      check("t200_mis", 32'(bp.mispredict), 32'd1);
      check("t200_cpc", bp.correct_pc, 32'h80);
      commit();
    end
    drive(32'h200, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    settle();
    check("q200_taken", 32'(bp.pred_taken), 32'd1);
    check("q200_npc", bp.npc, 32'h80);
    check("q200_miss", bp.perf_miss, 32'd2);
    commit();

    // Counter sits at 3: one not-taken keeps it taken, a second flips it.
    for (int k = 0; k < 2; k++) begin
      drive(32'h200, 1'b1, 32'h200, 0, 1'b0, 32'h0, 1'b1, 32'h80);
      step();
      drive(32'h200, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
      settle();
      check("hyst_taken", 32'(bp.pred_taken), (k == 0) ? 32'd1 : 32'd0);
      if (k == 1) check("hyst_npc", bp.npc, 32'h204);
      commit();
    end

    drive(32'h0, 1'b1, 32'h100, 1, 1'b1, 32'h900, 1'b0, 32'h0);
    step();
    drive(32'h0, 1'b1, 32'h200, 1, 1'b1, 32'hA00, 1'b0, 32'h0);
    step();
    drive(32'h100, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    settle();
    check("alias_100_hit", 32'(bp.btb_hit), 32'd0);
    commit();
    drive(32'h200, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    settle();
    check("alias_200_hit", 32'(bp.btb_hit), 32'd1);
    commit();

    drive(32'h300, 1'b1, 32'h300, 1, 1'b1, 32'hB00, 1'b0, 32'h0);
    settle();
    check("same_cyc_old", 32'(bp.pred_taken), 32'd0);
    commit();
    drive(32'h300, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    settle();
    check("same_cyc_new", 32'(bp.pred_taken), 32'd1);
    check("same_cyc_npc", bp.npc, 32'hB00);
    commit();

`ifdef BP_RAS_EN
    drive(32'h0, 1'b1, 32'h400, 2, 1'b1, 32'h800, 1'b0, 32'h0);
    step();
    drive(32'h0, 1'b1, 32'h500, 3, 1'b1, 32'h404, 1'b0, 32'h0);
    step();
    drive(32'h500, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    settle();
    check("ras_q500", bp.pred_target, 32'h404);
    commit();
    for (int k = 0; k < 5; k++) begin
      drive(32'h0, 1'b1, 32'h610 + 32'(k) * 32'h10, 2, 1'b1, 32'h800, 1'b0, 32'h0);
      step();
    end
    for (int k = 0; k < 5; k++) begin
      model_query(32'h500, h, ptk, ptg);
      drive(32'h500, 1'b1, 32'h500, 3, 1'b1, 32'h404, ptk, ptg);
      settle();
      check("ras_ret", bp.pred_target, (k == 4) ? 32'h404 : 32'h654 - 32'(k) * 32'h10);
      commit();
    end
`endif

    for (int i = 0; i < 400; i++) random_step();

    // Asynchronous reset between edges must drop trained state at once.
    drive(32'h0, 1'b1, 32'h700, 1, 1'b1, 32'hC00, 1'b0, 32'h0);
    step();
    drive(32'h700, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    settle();
    check("pre_arst_hit", 32'(bp.btb_hit), 32'd1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("arst_hit", 32'(bp.btb_hit), 32'd0);
    check("arst_taken", 32'(bp.pred_taken), 32'd0);
    check("arst_npc", bp.npc, 32'h704);
    check("arst_br", bp.perf_br, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor_param.md
# branch_predictor_param

Parametrised successor to the core's fixed-size predictor. It combines a direct-mapped BTB with a typed-entry field, a bimodal saturating-counter BHT of configurable width/depth, and an optional return-address stack. It also keeps saturating branch/mispredict performance counters.
- Sits between the IF-stage PC register and the next-PC mux.
- Queried combinationally with the fetch PC.
- Trained by the EX stage when a control-flow instruction resolves.

## Interface
Parameters:
- BTB_ENTRIES, 64: BTB depth; power of 2, ≥ 4.
- BHT_ENTRIES, 256: counter-table depth; power of 2, ≥ 4.
- CNT_BITS, 2: counter width, 1–4.
- RAS_DEPTH, 4: return-stack depth; power of 2; used only with the macro.

Ports:
- clk  in  1  core clock. One clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- query_pc  in  32  fetch PC (IF).
- pred_taken  out  1  predict redirect.
- pred_target  out  32  predicted target.
- npc  out  32  pred_taken ? pred_target : query_pc+4.
- btb_hit  out  1  valid entry with matching tag.
- upd_valid  in  1  EX resolves a branch/jump this cycle.
- upd_pc  in  32  PC of the resolving instruction.
- upd_type  in  2  0 cond, 1 jump, 2 call, 3 return.
- upd_taken  in  1  actual direction.
- upd_target  in  32  actual target.
- upd_pred_taken  in  1  prediction carried down the pipe.
- upd_pred_target  in  32  carried predicted target.
- mispredict  out  1  flush request.
- correct_pc  out  32  redirect PC on mispredict.
- perf_br  out  32  resolved-branch count.
- perf_miss  out  32  mispredict count.

## Operation
Indexing:
- BTB index = pc[log2(BTB_ENTRIES)+1:2]; tag = remaining upper bits.
- BHT index = pc[log2(BHT_ENTRIES)+1:2].
- pc[1:0] is ignored.

BTB entry contents: {valid, tag, target[31:0], type[1:0]}.

Query (combinational from tables):
- type 0: pred_taken = btb_hit & counter MSB.
- types 1–3: pred_taken = btb_hit.
- pred_target = entry target, except type 3 with a non-empty RAS, which uses the RAS top.

Update (at the clock edge when upd_valid):
- BTB is written (valid=1, tag, upd_target, upd_type) only when upd_taken. A not-taken resolution never allocates or invalidates an entry.
- Direct-mapped: a conflicting tag is overwritten.
- BHT counter for upd_pc is updated only for type 0: +1 if taken, −1 if not, saturating at 0 and 2^CNT_BITS−1.

Mispredict (combinational):
- mispredict = upd_valid & ((upd_taken ≠ upd_pred_taken) | (upd_taken & upd_pred_target ≠ upd_target)).
- correct_pc = upd_taken ? upd_target : upd_pc+4.

Performance counters:
- perf_br increments on every upd_valid.
- perf_miss increments on every mispredict.
- Both saturate at 0xFFFF_FFFF.

Reset values:
- All valid bits = 0.
- Counters = 2^(CNT_BITS−1)−1 (weakly not-taken); with CNT_BITS=1 this is 0.
- perf_br = perf_miss = 0; RAS empty.
- Outputs during reset: pred_taken=0, btb_hit=0, npc=query_pc+4, mispredict follows its inputs.
- Reset asserted mid-operation discards all trained state immediately (asynchronous).

## Timing
- Query latency 0: outputs are combinational in query_pc.
- Update becomes visible to a query on the cycle after the edge.
- Same-cycle query and update to the same index: the query sees the old contents (no bypass).
- mispredict and correct_pc are valid in the same cycle as upd_valid.
- At most one update per cycle. The block has no internal state machine beyond tables, counters and the RAS pointer.

## Configuration
- BP_RAS_EN defined: RAS of RAS_DEPTH entries, trained non-speculatively at resolution.
  - Call: push upd_pc+4.
  - Return: pop.
  - Push when full overwrites the oldest entry (circular); occupancy saturates at RAS_DEPTH.
  - Pop when empty is ignored.
  - A return hit while the RAS is empty falls back to the BTB target.
- BP_RAS_EN undefined: no RAS logic. Types 2 and 3 behave exactly as type 1 (BTB target).

## Structure
- Shared package bp_pkg holds:
  - br_type_e enum (COND, JUMP, CALL, RET);
  - the counter reset-value function;
  - the saturating-increment helper.
- One sub-module, bp_ras, instantiated only under BP_RAS_EN; holds the stack array, top pointer and occupancy count.

## Test plan
- Reset, then query 0x100 → pred_taken=0, btb_hit=0, npc=0x104, perf_br=0.
- Type-0 branch at 0x200, taken to 0x80, resolved 2× with pred_taken=0:
  - first update → mispredict=1, correct_pc=0x80;
  - after both, query 0x200 → pred_taken=1, npc=0x80, perf_miss=2.
- Train 0x200 to counter 3, then resolve not-taken once → still predicts taken; a second not-taken → predicts not-taken, npc=0x204.
- Aliasing: with BTB_ENTRIES=64, taken at 0x100 and then 0x200 (same index) → query 0x100 misses, 0x200 hits.
- Same-cycle update and query of 0x300 → old prediction that cycle, new prediction the next.
- BP_RAS_EN: call at 0x400 resolved, then return entry at 0x500 trained → query 0x500 gives pred_target=0x404. Five calls with RAS_DEPTH=4 then five returns → the last return falls back to the BTB target.
